// File: rtl/uart_frame_sched.sv
// Frame tick scheduler and per-byte ROM server for the RS-485 UART transmitter; flags stalled frames and missed ticks.
// Define FRAME_CNT_EN to add the 16-bit completed-frame counter output frameCnt.
module uart_frame_sched #(
    parameter int BYTES   = 4,
    parameter int CYCLES  = 64,
    parameter int PERIOD  = 2400,
    parameter int TIMEOUT = 1023,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        full,
    input  logic        rqRom,
    input  logic [7:0]  memData,
    input  logic        errClr,
    output logic        RQ,
    output logic        ack,
    output logic [5:0]  cycle,
    output logic [7:0]  data,
    output logic        memRd,
    output logic [8:0]  memAddr,
    output logic        busy,
    output logic        frameDone,
    output logic        timeoutErr,
    output logic        overrun
`ifdef FRAME_CNT_EN
    ,
    output logic [15:0] frameCnt
`endif
);

    localparam int PW = $clog2(PERIOD);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE, ST_ABORT} state_t;
    typedef enum logic [1:0] {BY_FREE, BY_LAT, BY_ACK} byte_t;

    state_t        state, state_nx;
    byte_t         byte_st, byte_nx;
    logic [PW-1:0] per_cnt;
    logic [WW-1:0] wd_cnt;
    logic [BW-1:0] byte_idx;
    logic [1:0]    lat_cnt;
    logic          tick;
    logic          rd_go, latch_go, rel_go, done_go, abort_go;

    assign tick = enable && (per_cnt == PW'(PERIOD - 1));
    assign RQ   = (state == ST_SEND);
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            byte_st <= BY_FREE;
        end else begin
            state   <= state_nx;
            byte_st <= byte_nx;
        end
    end

    // full beats the watchdog; either exit abandons whatever byte is in flight
    always_comb begin
        state_nx = state;
        byte_nx  = byte_st;
        rd_go    = 1'b0;
        latch_go = 1'b0;
        rel_go   = 1'b0;
        done_go  = 1'b0;
        abort_go = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_nx = ST_SEND;
                    byte_nx  = BY_FREE;
                end
            end
            ST_SEND: begin
                if (full) begin
                    state_nx = ST_DONE;
                    done_go  = 1'b1;
                end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
                    state_nx = ST_ABORT;
                    abort_go = 1'b1;
                end else begin
                    case (byte_st)
                        BY_FREE: if (rqRom && !ack) begin
                            rd_go   = 1'b1;
                            byte_nx = BY_LAT;
                        end
                        BY_LAT: if (lat_cnt == 2'(MEM_LAT)) begin
                            latch_go = 1'b1;
                            byte_nx  = BY_ACK;
                        end
                        BY_ACK: if (!rqRom) begin
                            rel_go  = 1'b1;
                            byte_nx = BY_FREE;
                        end
                        default: byte_nx = BY_FREE;
                    endcase
                end
            end
            ST_DONE, ST_ABORT: begin
                if (!full) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt    <= '0;
            wd_cnt     <= '0;
            byte_idx   <= '0;
            lat_cnt    <= '0;
            ack        <= 1'b0;
            cycle      <= '0;
            data       <= '0;
            memRd      <= 1'b0;
            memAddr    <= '0;
            frameDone  <= 1'b0;
            timeoutErr <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            per_cnt <= (!enable || tick) ? '0 : per_cnt + 1'b1;

            memRd <= rd_go;
            if (rd_go)
                memAddr <= 9'(cycle) * 9'(BYTES) + 9'(byte_idx);

            // lat_cnt==0 in the strobe clock, so memData is taken MEM_LAT clocks after it
            if (rd_go)
                lat_cnt <= '0;
            else if (state == ST_SEND && byte_st == BY_LAT)
                lat_cnt <= lat_cnt + 1'b1;

            if (latch_go)
                data <= memData;

            if (latch_go)
                ack <= 1'b1;
            else if (rel_go || state_nx != ST_SEND)
                ack <= 1'b0;

            if (state == ST_IDLE) begin
                wd_cnt   <= '0;
                byte_idx <= '0;
            end else begin
                if (state == ST_SEND)
                    wd_cnt <= wd_cnt + 1'b1;
                if (rel_go)
                    byte_idx <= (byte_idx == BW'(BYTES - 1)) ? '0 : byte_idx + 1'b1;
            end

            frameDone <= done_go;
            if (done_go)
                cycle <= (cycle == 6'(CYCLES - 1)) ? '0 : cycle + 1'b1;

            if (abort_go)
                timeoutErr <= 1'b1;
            else if (errClr)
                timeoutErr <= 1'b0;

            if (tick && state != ST_IDLE)
                overrun <= 1'b1;
            else if (errClr)
                overrun <= 1'b0;
        end
    end

`ifdef FRAME_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frameCnt <= '0;
        else if (done_go)
            frameCnt <= frameCnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_uart_frame_sched.sv
// Randomized transmitter/memory bench for uart_frame_sched with a transaction-level scoreboard.
module tb_uart_frame_sched;

    localparam int BYTES   = 4;
    localparam int CYCLES  = 64;
    localparam int PERIOD  = 64;
    localparam int TIMEOUT = 50;
    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset, enable, full, rqRom, errClr;
    logic [7:0]  memData;
    logic        RQ, ack, memRd, busy, frameDone, timeoutErr, overrun;
    logic [5:0]  cycle;
    logic [7:0]  data;
    logic [8:0]  memAddr;
`ifdef FRAME_CNT_EN
    logic [15:0] frameCnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    int clk_n = 0;

    logic [7:0] mem [512];
    bit         pipe_v [4];
    bit [8:0]   pipe_a [4];

    int exp_cycle, exp_cnt, en_clk;
    bit fresh, exp_ovr, exp_to;

    uart_frame_sched #(
        .BYTES(BYTES), .CYCLES(CYCLES), .PERIOD(PERIOD),
        .TIMEOUT(TIMEOUT), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .full(full),
        .rqRom(rqRom), .memData(memData), .errClr(errClr),
        .RQ(RQ), .ack(ack), .cycle(cycle), .data(data),
        .memRd(memRd), .memAddr(memAddr), .busy(busy),
        .frameDone(frameDone), .timeoutErr(timeoutErr), .overrun(overrun)
`ifdef FRAME_CNT_EN
        , .frameCnt(frameCnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) clk_n <= clk_n + 1;

    // Synchronous memory: a read strobed in cycle c is visible throughout cycle c+MEM_LAT only
    always @(negedge clk) begin
        for (int i = 3; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_a[i] = pipe_a[i-1];
        end
        pipe_v[0] = memRd;
        pipe_a[0] = memAddr;
    end
    assign memData = pipe_v[MEM_LAT] ? mem[pipe_a[MEM_LAT]] : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_rq(input int limit, output bit ok, output int t);
        int n;
        n = 0; ok = 0; t = 0;
        while (n < limit && !ok) begin
            @(negedge clk);
            n++;
            if (RQ) begin ok = 1; t = clk_n; end
        end
    endtask

    task automatic check_rise(input int t);
        if (fresh) chk("first_rq_clock", t - en_clk, PERIOD);
        else       chk("tick_phase", (t - en_clk) % PERIOD, 0);
        fresh = 0;
    endtask

    task automatic end_flags();
        chk("overrun_flag", overrun, exp_ovr);
        chk("timeout_flag", timeoutErr, exp_to);
`ifdef FRAME_CNT_EN
        chk("frame_cnt", frameCnt, exp_cnt);
`endif
    endtask

    task automatic serve_frame(input int hold, input bit drop_en);
        bit ok;
        int t, n, a, rq_seen;
        wait_rq(3 * PERIOD, ok, t);
        chk("rq_rise", ok, 1);
        if (!ok) return;
        check_rise(t);
        chk("busy_send", busy, 1);
        for (int k = 0; k < BYTES; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rqRom = 1;
            n = 0;
            do begin @(negedge clk); n++; end while (!memRd && n < 20);
            a = (exp_cycle * BYTES + k) % 512;
            chk("mem_addr", memAddr, a);
            n = 0;
            do begin @(negedge clk); n++; end while (!ack && n < 20);
            chk("ack_latency", n, MEM_LAT + 1);
            chk("byte_data", data, mem[a]);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("no_read_while_ack", memRd, 0);
            end
            rqRom = 0;
            @(negedge clk);
            chk("ack_release", ack, 0);
            if (drop_en && k == 1) enable = 0;
        end
        full = 1;
        @(negedge clk);
        chk("rq_drop", RQ, 0);
        chk("frame_done", frameDone, 1);
        exp_cycle = (exp_cycle + 1) % CYCLES;
        exp_cnt++;
        chk("cycle_next", cycle, exp_cycle);
        rq_seen = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 0) chk("done_one_clock", frameDone, 0);
            rq_seen += int'(RQ);
        end
        chk("no_rq_while_full", rq_seen, 0);
        full = 0;
        @(negedge clk);
        chk("idle_after_done", busy, 0);
        if (hold > PERIOD) exp_ovr = 1;
        end_flags();
    endtask

    task automatic watchdog_frame();
        bit ok;
        int t, n;
        wait_rq(3 * PERIOD, ok, t);
        chk("wd_rq_rise", ok, 1);
        if (!ok) return;
        check_rise(t);
        n = 0;
        do begin n++; @(negedge clk); end while (RQ && n < 4 * TIMEOUT);
        chk("watchdog_len", n, TIMEOUT);
        chk("abort_no_done", frameDone, 0);
        chk("abort_cycle_kept", cycle, exp_cycle);
        chk("abort_ack_low", ack, 0);
        exp_to = 1;
        @(negedge clk);
        chk("abort_to_idle", busy, 0);
        end_flags();
    endtask

    task automatic clear_errors();
        errClr = 1;
        @(negedge clk);
        errClr = 0;
        exp_to = 0;
        exp_ovr = 0;
        end_flags();
    endtask

    task automatic stale_full_frame();
        bit ok;
        int t;
        full = 1;
        wait_rq(3 * PERIOD, ok, t);
        chk("stale_rq_rise", ok, 1);
        if (!ok) return;
        check_rise(t);
        @(negedge clk);
        chk("stale_rq_drop", RQ, 0);
        chk("stale_done", frameDone, 1);
        exp_cycle = (exp_cycle + 1) % CYCLES;
        exp_cnt++;
        chk("stale_cycle", cycle, exp_cycle);
        full = 0;
        @(negedge clk);
        chk("stale_idle", busy, 0);
    endtask

    task automatic reset_mid_byte();
        bit ok;
        int t, n;
        wait_rq(3 * PERIOD, ok, t);
        chk("rst_rq_rise", ok, 1);
        if (!ok) return;
        check_rise(t);
        rqRom = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ack && n < 20);
        chk("ack_before_reset", ack, 1);
        reset = 1;
        #1;
        chk("rst_rq", RQ, 0);
        chk("rst_ack", ack, 0);
        chk("rst_memrd", memRd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cycle", cycle, 0);
        chk("rst_data", data, 0);
        rqRom = 0;
        @(negedge clk);
        reset = 0;
        en_clk = clk_n;
        fresh = 1;
        exp_cycle = 0;
        exp_cnt = 0;
        exp_ovr = 0;
        exp_to = 0;
    endtask

    initial begin
        int rq_seen;
        reset = 1; enable = 0; full = 0; rqRom = 0; errClr = 0;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        exp_cycle = 0; exp_cnt = 0; exp_ovr = 0; exp_to = 0; fresh = 1; en_clk = 0;
        repeat (3) @(negedge clk);
        chk("reset_rq", RQ, 0);
        chk("reset_ack", ack, 0);
        chk("reset_cycle", cycle, 0);
        chk("reset_data", data, 0);
        chk("reset_memrd", memRd, 0);
        chk("reset_memaddr", memAddr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", frameDone, 0);
        end_flags();
        reset = 0;
        repeat (2 * PERIOD) @(negedge clk);
        chk("disabled_stays_idle", busy, 0);

        enable = 1; en_clk = clk_n; fresh = 1;
        for (int i = 0; i < 3; i++) serve_frame($urandom_range(1, 4), 0);

        watchdog_frame();
        clear_errors();
        serve_frame($urandom_range(1, 4), 0);

        serve_frame(PERIOD + 16, 0);
        clear_errors();
        serve_frame($urandom_range(1, 4), 0);

        stale_full_frame();

        serve_frame($urandom_range(1, 4), 1);
        rq_seen = 0;
        repeat (3 * PERIOD) begin
            @(negedge clk);
            rq_seen += int'(RQ);
        end
        chk("no_frame_after_disable", rq_seen, 0);
        enable = 1; en_clk = clk_n; fresh = 1;

        for (int i = 0; i < CYCLES + 2; i++) serve_frame($urandom_range(1, 4), 0);

        reset_mid_byte();
        for (int i = 0; i < 2; i++) serve_frame($urandom_range(1, 4), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no completion, expected finish before t=%0t", $time);
        $fatal(1, "bench time limit reached");
    end

endmodule
